// File: rtl/cv32e40px_obi_instr_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cv32e40px_obi_instr_responder
//  Description : OBI instruction-fetch responder backed by a synchronous
//                SRAM port. Provides configurable grant stalling, a bounded
//                number of outstanding transactions, a fixed response delay
//                and bus-error responses for out-of-range addresses.
//  Revision    : 1.0 - initial release
// ============================================================================
module cv32e40px_obi_instr_responder #(
   parameter logic [31:0] MEM_BASE        = 32'h0000_0000,
   parameter int unsigned MEM_WORDS       = 1024,
   parameter int unsigned RESP_DELAY      = 1,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter int unsigned GNT_STALL       = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         instr_req_i,
   input  logic [31:0]                  instr_addr_i,
   output logic                         instr_gnt_o,
   output logic                         instr_rvalid_o,
   output logic [31:0]                  instr_rdata_o,
   output logic                         instr_err_o,
   input  logic                         gnt_block_i,
   output logic                         mem_req_o,
   output logic [$clog2(MEM_WORDS)-1:0] mem_addr_o,
   input  logic [31:0]                  mem_rdata_i,
   output logic [2:0]                   outstanding_o,
   output logic                         busy_o
);

   localparam int          AW        = $clog2(MEM_WORDS);
   localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);
   localparam logic [2:0]  MAX_OUT   = 3'(MAX_OUTSTANDING);
   localparam logic [2:0]  STALL_MAX = 3'(GNT_STALL);

   logic [2:0]  outstanding;
   logic [2:0]  stall_cnt;
   logic [31:0] offset;
   logic        in_range;
   logic        handshake;

   // First response stage: the cycle right after the grant, when SRAM data is valid
   logic        s1_valid;
   logic        s1_err;
   logic [31:0] s1_data;

   // Final response stage presented on the bus
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_data;

   // Unsigned wrap makes addresses below MEM_BASE land far out of range
   assign offset   = instr_addr_i - MEM_BASE;
   assign in_range = (offset < MEM_BYTES);

   // Grant is forced low during reset even though it is purely combinational
   assign instr_gnt_o = rst_n & instr_req_i & ~gnt_block_i &
                        (outstanding < MAX_OUT) & (stall_cnt == STALL_MAX);
   assign handshake   = instr_req_i & instr_gnt_o;

   assign mem_req_o  = handshake & in_range;
   assign mem_addr_o = offset[AW+1:2];

   // Track consecutive request cycles without a grant, saturating at the stall limit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= 3'd0;
      end else if (!instr_req_i || handshake) begin
         stall_cnt <= 3'd0;
      end else if (stall_cnt != STALL_MAX) begin
         stall_cnt <= stall_cnt + 3'd1;
      end
   end

   // Outstanding count: the slot freed by a response is only visible next cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outstanding <= 3'd0;
      end else if (handshake && !resp_valid) begin
         outstanding <= outstanding + 3'd1;
      end else if (!handshake && resp_valid) begin
         outstanding <= outstanding - 3'd1;
      end
   end

   // Remember that a grant happened and whether it hit the SRAM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_err   <= 1'b0;
      end else begin
         s1_valid <= handshake;
         s1_err   <= handshake & ~in_range;
      end
   end

   // Error responses carry zero data; good responses take the SRAM word
   assign s1_data = (s1_valid && !s1_err) ? mem_rdata_i : 32'h0;

   generate
      if (RESP_DELAY == 1) begin : g_direct
         assign resp_valid = s1_valid;
         assign resp_err   = s1_err;
         assign resp_data  = s1_data;
      end else begin : g_delay
         localparam int DL = RESP_DELAY - 1;

         logic [DL-1:0] dl_valid;
         logic [DL-1:0] dl_err;
         logic [31:0]   dl_data [DL];

         // Delay line that holds captured responses until their due cycle
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               dl_valid <= '0;
               dl_err   <= '0;
               for (int k = 0; k < DL; k++) begin
                  dl_data[k] <= 32'h0;
               end
            end else begin
               dl_valid[0] <= s1_valid;
               dl_err[0]   <= s1_err;
               dl_data[0]  <= s1_data;
               for (int k = 1; k < DL; k++) begin
                  dl_valid[k] <= dl_valid[k-1];
                  dl_err[k]   <= dl_err[k-1];
                  dl_data[k]  <= dl_data[k-1];
               end
            end
         end

         assign resp_valid = dl_valid[DL-1];
         assign resp_err   = dl_err[DL-1];
         assign resp_data  = dl_data[DL-1];
      end
   endgenerate

   // Data and error are qualified by rvalid so the bus is quiet between responses
   assign instr_rvalid_o = resp_valid;
   assign instr_err_o    = resp_valid & resp_err;
   assign instr_rdata_o  = resp_valid ? resp_data : 32'h0;

   assign outstanding_o = outstanding;
   assign busy_o        = (outstanding != 3'd0);

endmodule
`default_nettype wire

// File: tb/tb_cv32e40px_obi_instr_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_cv32e40px_obi_instr_responder
//  Description : Self-checking bench driving three responder configurations
//                against a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cv32e40px_obi_instr_responder;

   localparam int N = 3;

   typedef struct {
      int          inst;
      int          due;
      logic [31:0] data;
      logic        err;
   } resp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0] req, block, gnt, rvalid, err, mem_req, busy;
   logic [31:0]  addr      [N];
   logic [31:0]  rdata     [N];
   logic [31:0]  mem_rdata [N];
   logic [9:0]   mem_addr  [N];
   logic [2:0]   outst     [N];

   // Instance configurations: 0 = defaults, 1 = offset base with delay 2,
   // 2 = grant stall 3, delay 3, three outstanding
   function automatic logic [31:0] base_of(int i);
      return (i == 1) ? 32'h100 : 32'h0;
   endfunction
   function automatic int dly_of(int i);
      return i + 1;
   endfunction
   function automatic int maxo_of(int i);
      return (i == 2) ? 3 : 2;
   endfunction
   function automatic int stall_of(int i);
      return (i == 2) ? 3 : 0;
   endfunction

   generate
      for (genvar g = 0; g < N; g++) begin : g_dut
         cv32e40px_obi_instr_responder #(
            .MEM_BASE        (g == 1 ? 32'h100 : 32'h0),
            .MEM_WORDS       (1024),
            .RESP_DELAY      (g + 1),
            .MAX_OUTSTANDING (g == 2 ? 3 : 2),
            .GNT_STALL       (g == 2 ? 3 : 0)
         ) u_dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .instr_req_i    (req[g]),
            .instr_addr_i   (addr[g]),
            .instr_gnt_o    (gnt[g]),
            .instr_rvalid_o (rvalid[g]),
            .instr_rdata_o  (rdata[g]),
            .instr_err_o    (err[g]),
            .gnt_block_i    (block[g]),
            .mem_req_o      (mem_req[g]),
            .mem_addr_o     (mem_addr[g]),
            .mem_rdata_i    (mem_rdata[g]),
            .outstanding_o  (outst[g]),
            .busy_o         (busy[g])
         );
      end
   endgenerate

   function automatic logic [31:0] mem_word(int i, int w);
      if (i == 0 && w == 4) return 32'hDEADBEEF;
      return (32'(w) * 32'h9E3779B1) ^ (32'(i) << 28) ^ 32'h0BAD_0000;
   endfunction

   // SRAM models: one-cycle read latency, garbage when not read
   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         mem_rdata[i] <= mem_req[i] ? mem_word(i, int'(mem_addr[i])) : $urandom();
      end
   end

   resp_t        pend[$];
   int           waited [N];
   int           cyc;
   int           n_checks;
   int           n_fail;
   logic [N-1:0] hs;
   logic [N-1:0] rv;
   logic [N-1:0] inr_s;
   logic [31:0]  off_s [N];

   task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s[%0d] cyc %0d: observed %h expected %h", tag, i, cyc, obs, exp);
      end
   endtask

   function automatic int first_of(int i);
      for (int k = 0; k < pend.size(); k++) begin
         if (pend[k].inst == i) return k;
      end
      return -1;
   endfunction

   // One clock: check every output at the falling edge, then advance the model
   task automatic step();
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         int          cnt;
         int          fi;
         logic [31:0] off;
         logic        inr, eg, ev;
         resp_t       fr;
         cnt = 0;
         for (int k = 0; k < pend.size(); k++) begin
            if (pend[k].inst == i) cnt++;
         end
         fi  = first_of(i);
         off = addr[i] - base_of(i);
         inr = (off < 32'd4096);
         eg  = rst_n && req[i] && !block[i] && (cnt < maxo_of(i)) && (waited[i] >= stall_of(i));
         ev  = 1'b0;
         fr.data = 32'h0;
         fr.err  = 1'b0;
         if (rst_n && fi >= 0 && pend[fi].due == cyc) begin
            ev = 1'b1;
            fr = pend[fi];
         end
         chk("gnt", i, 32'(gnt[i]), 32'(eg));
         chk("mem_req", i, 32'(mem_req[i]), 32'(eg && inr));
         if (eg && inr) chk("mem_addr", i, 32'(mem_addr[i]), 32'(off[11:2]));
         chk("rvalid", i, 32'(rvalid[i]), 32'(ev));
         chk("rdata", i, rdata[i], ev ? fr.data : 32'h0);
         chk("err", i, 32'(err[i]), 32'(ev && fr.err));
         chk("outstanding", i, 32'(outst[i]), rst_n ? 32'(cnt) : 32'h0);
         chk("busy", i, 32'(busy[i]), 32'(rst_n && cnt != 0));
         hs[i]    = eg;
         rv[i]    = ev;
         inr_s[i] = inr;
         off_s[i] = off;
      end
      @(posedge clk);
      if (!rst_n) begin
         pend.delete();
         for (int i = 0; i < N; i++) waited[i] = 0;
      end else begin
         for (int i = 0; i < N; i++) begin
            resp_t r;
            if (rv[i]) pend.delete(first_of(i));
            if (hs[i]) begin
               r.inst = i;
               r.due  = cyc + dly_of(i);
               r.err  = !inr_s[i];
               r.data = inr_s[i] ? mem_word(i, int'(off_s[i][11:2])) : 32'h0;
               pend.push_back(r);
            end
            waited[i] = hs[i] ? 0 : (req[i] ? waited[i] + 1 : 0);
         end
      end
      cyc++;
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   // Hold a request on instance i until n grants, advancing the address per grant
   task automatic burst(input int i, input logic [31:0] start, input int n, output int cycles);
      int got;
      got    = 0;
      cycles = 0;
      req[i]  = 1'b1;
      addr[i] = start;
      while (got < n && cycles < 40) begin
         step();
         cycles++;
         if (hs[i]) begin
            got++;
            addr[i] = addr[i] + 32'd4;
         end
      end
      req[i] = 1'b0;
      chk("burst_grants", i, 32'(got), 32'(n));
   endtask

   initial begin
      int cy;
      int r;
      n_checks = 0;
      n_fail   = 0;
      cyc      = 0;
      req      = '0;
      block    = '0;
      for (int i = 0; i < N; i++) begin
         addr[i]   = 32'h0;
         waited[i] = 0;
      end

      // Reset with requests pending: grant must stay low
      req = '1;
      idle(2);
      rst_n = 1'b1;
      req   = '0;
      idle(2);

      // Single read of word 4
      burst(0, 32'h10, 1, cy);
      chk("single_rvalid", 0, 32'(rvalid[0]), 32'h1);
      chk("single_rdata", 0, rdata[0], 32'hDEADBEEF);
      idle(2);

      // Back-to-back requests against the outstanding limit
      burst(0, 32'h0, 3, cy);
      chk("b2b_cycles_d1", 0, 32'(cy), 32'd3);
      idle(3);
      burst(1, 32'h100, 3, cy);
      chk("b2b_cycles_d2", 1, 32'(cy), 32'd4);
      idle(4);

      // Address range boundaries
      burst(0, 32'h1000, 1, cy);
      chk("oor_err", 0, 32'(err[0]), 32'h1);
      idle(2);
      burst(0, 32'hFFC, 1, cy);
      idle(2);
      burst(1, 32'hFC, 1, cy);
      idle(3);
      burst(1, 32'h10FC, 2, cy);
      idle(3);

      // Grant stall and grant blocking, with the address wandering before grant
      burst(2, 32'h20, 1, cy);
      chk("stall_cycles", 2, 32'(cy), 32'd4);
      idle(4);
      req[2]   = 1'b1;
      block[2] = 1'b1;
      for (int k = 0; k < 8; k++) begin
         addr[2] = $urandom();
         step();
      end
      block[2] = 1'b0;
      burst(2, 32'h40, 1, cy);
      idle(5);

      // Reset with two transactions in flight
      burst(1, 32'h200, 2, cy);
      chk("pre_reset_outst", 1, 32'(outst[1]), 32'd2);
      rst_n = 1'b0;
      #1;
      chk("reset_async_rvalid", 1, 32'(rvalid[1]), 32'h0);
      step();
      rst_n = 1'b1;
      idle(4);
      burst(1, 32'h104, 1, cy);
      idle(3);

      // Randomized traffic on all instances
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            req[i]   = ($urandom_range(0, 99) < 60);
            block[i] = ($urandom_range(0, 99) < 15);
            r = int'($urandom_range(0, 9));
            if (r < 7)       addr[i] = base_of(i) + (32'($urandom_range(0, 1023)) << 2) + 32'($urandom_range(0, 3));
            else if (r == 7) addr[i] = base_of(i) + 32'd4096 + 32'($urandom_range(0, 255));
            else if (r == 8) addr[i] = base_of(i) - 32'd4;
            else             addr[i] = $urandom();
         end
         step();
      end
      req   = '0;
      block = '0;
      idle(6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
